// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sprite RAM widths, sprite descriptor field layout and
// the arbiter FSM state encoding.
package sprite_pkg;

    localparam int SPRITE_ADDR_W = 3;
    localparam int SPRITE_DATA_W = 32;

    // Descriptor word as stored in the sprite attribute RAM (MSB first).
    typedef struct packed {
        logic [4:0] tag;
        logic       flag;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] row;
        logic [2:0] col;
    } sprite_desc_t;

    typedef enum logic {
        ARB   = 1'b0,
        WRITE = 1'b1
    } arb_state_t;

    // Pointer width that still works for the degenerate single-bit case.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_ram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first asserted
// request at or after ptr (circularly) as a one-hot vector.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] win,
    output logic             valid
);

    logic [N_REQ-1:0] req_rot;
    logic [N_REQ-1:0] first_rot;

    // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        req_rot   = N_REQ'({req, req} >> ptr);
        first_rot = req_rot & (~req_rot + N_REQ'(1));
        win       = N_REQ'(({first_rot, first_rot} << ptr) >> N_REQ);
        valid     = |req;
    end

endmodule

// File: rtl/sprite_ram_arbiter.sv
// sprite_ram_arbiter: round-robin arbiter granting sprite-descriptor writers
// one-cycle access to the sprite attribute RAM write port, and tracking which
// requesters have written during the current frame.
// Optional build macro SPRITE_ARB_VBLANK_GATE_EN: when defined, new grants
// are only issued while vblank is high.
//
// state | meaning
// ------+-------------------------------------------------------------
// ARB   | pick a winner, capture its addr/data, set up the write
// WRITE | wea/gnt asserted for exactly this one cycle
module sprite_ram_arbiter
    import sprite_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = SPRITE_ADDR_W,
    parameter int DATA_W = SPRITE_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    input  logic                     vblank,
    output logic [N_REQ-1:0]         gnt,
    output logic                     wea,
    output logic [ADDR_W-1:0]        addra,
    output logic [DATA_W-1:0]        dina,
    output logic                     frame_done
);

    localparam int PTR_W = ptr_width(N_REQ);

    arb_state_t         state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   next_ptr;
    logic [N_REQ-1:0]   mask;
    logic [N_REQ-1:0]   mask_base;
    logic [N_REQ-1:0]   mask_granted;
    logic [N_REQ-1:0]   pick_win;
    logic               pick_valid;
    logic               vblank_q;
    logic               vblank_rise;
    logic               eligible;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .win   (pick_win),
        .valid (pick_valid)
    );

    // A new frame starts on the vblank rising edge; a grant in that same
    // cycle is applied after the clear so it counts toward the new frame.
    assign vblank_rise  = vblank & ~vblank_q;
    assign mask_base    = vblank_rise ? '0 : mask;
    assign mask_granted = mask_base | pick_win;

`ifdef SPRITE_ARB_VBLANK_GATE_EN
    assign eligible = vblank;
`else
    assign eligible = 1'b1;
`endif

    // Steer the winner's address/data and derive the pointer that follows it.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        next_ptr = rr_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_win[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
                next_ptr = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    // Arbitration FSM with registered write-port, grant and frame outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB;
            rr_ptr     <= '0;
            mask       <= '0;
            gnt        <= '0;
            wea        <= 1'b0;
            addra      <= '0;
            dina       <= '0;
            frame_done <= 1'b0;
            vblank_q   <= 1'b0;
        end else begin
            vblank_q   <= vblank;
            frame_done <= 1'b0;
            mask       <= mask_base;
            case (state)
                ARB: begin
                    if (eligible && pick_valid) begin
                        state      <= WRITE;
                        gnt        <= pick_win;
                        wea        <= 1'b1;
                        addra      <= sel_addr;
                        dina       <= sel_data;
                        rr_ptr     <= next_ptr;
                        mask       <= mask_granted;
                        frame_done <= (&mask_granted) && !(&mask_base);
                    end
                end
                WRITE: begin
                    state <= ARB;
                    gnt   <= '0;
                    wea   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// Bench for sprite_ram_arbiter: directed scenarios with literal expectations
// plus a long randomized run, all compared every cycle against a
// behavioural model of the arbitration and frame rules.
module tb_sprite_ram_arbiter;

    localparam int N  = 4;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int FULL = (1 << N) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*AW-1:0]  req_addr = '0;
    logic [N*DW-1:0]  req_data = '0;
    logic             vblank = 1'b0;
    logic [N-1:0]     gnt;
    logic             wea;
    logic [AW-1:0]    addra;
    logic [DW-1:0]    dina;
    logic             frame_done;

    sprite_ram_arbiter #(
        .N_REQ  (N),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .vblank     (vblank),
        .gnt        (gnt),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: a grant occupies the cycle after the decision, the
    // port is then idle for one cycle; winner is the first requester found
    // walking circularly from the pointer.
    logic          m_live = 1'b0;
    logic          m_wea = 1'b0;
    logic          m_fd = 1'b0;
    logic [N-1:0]  m_gnt = '0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    int            m_ptr = 0;
    int            m_mask = 0;
    bit            m_vprev = 1'b0;
    bit            m_busy = 1'b0;

    always @(posedge clk) begin
        int w;
        bit elig;
        bit rise;
        if (reset) begin
            m_live = 1'b1; m_wea = 1'b0; m_gnt = '0; m_addr = '0; m_data = '0;
            m_fd = 1'b0; m_ptr = 0; m_mask = 0; m_vprev = 1'b0; m_busy = 1'b0;
        end else if (m_live) begin
            rise = vblank && !m_vprev;
            m_vprev = vblank;
            if (rise) m_mask = 0;
            m_fd = 1'b0; m_wea = 1'b0; m_gnt = '0;
`ifdef SPRITE_ARB_VBLANK_GATE_EN
            elig = vblank;
`else
            elig = 1'b1;
`endif
            if (m_busy) begin
                m_busy = 1'b0;
            end else if (elig && req != '0) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                m_busy = 1'b1;
                m_wea  = 1'b1;
                m_gnt  = N'(1) << w;
                m_addr = req_addr[w*AW +: AW];
                m_data = req_data[w*DW +: DW];
                m_ptr  = (w + 1) % N;
                m_fd   = (m_mask != FULL) && ((m_mask | (1 << w)) == FULL);
                m_mask = m_mask | (1 << w);
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_live) begin
            chk("gnt",        gnt,        m_gnt);
            chk("wea",        wea,        m_wea);
            chk("addra",      addra,      m_addr);
            chk("dina",       dina,       m_data);
            chk("frame_done", frame_done, m_fd);
        end
    end

    int fd_seen = 0;
    int fd_g2   = 0;
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            fd_seen++;
            if (gnt == 4'b0100) fd_g2++;
        end
    end

    initial begin
        int fd0, fg0, g0cnt, g2cnt, bad5;
        int order [4] = '{3, 1, 0, 2};

        repeat (3) @(negedge clk);
        chk("rst_wea",   wea,        0);
        chk("rst_gnt",   gnt,        0);
        chk("rst_addra", addra,      0);
        chk("rst_dina",  dina,       0);
        chk("rst_fd",    frame_done, 0);
        reset = 1'b0;

        // Single requester, one-cycle latency.
        req = 4'b0001; req_addr[0 +: AW] = '0; req_data[0 +: DW] = 32'h8000_0000;
        @(negedge clk);
        chk("first_wea",   wea,   1);
        chk("first_gnt",   gnt,   4'b0001);
        chk("first_addra", addra, 0);
        chk("first_dina",  dina,  32'h8000_0000);
        req = '0;
        @(negedge clk);
        chk("idle_wea",  wea,  0);
        chk("idle_gnt",  gnt,  0);
        chk("hold_dina", dina, 32'h8000_0000);

        // All requesting: grants 0,1,2,3,0 every second cycle.
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = AW'(7 - i);
            req_data[i*DW +: DW] = 32'hA000_0000 + i;
        end
        req = '1;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (j % 2 == 1) begin
                chk("rr_gnt",  gnt,  1 << (((j - 1) / 2) % 4));
                chk("rr_dina", dina, 32'hA000_0000 + (((j - 1) / 2) % 4));
            end else begin
                chk("rr_gap", gnt, 0);
            end
            chk("rr_fd", frame_done, (j == 7) ? 1 : 0);
        end
        req = '0;

        // New frame on vblank rise, then grants 3,1,0,2.
        fd0 = fd_seen; fg0 = fd_g2;
        vblank = 1'b1;
        @(negedge clk);
        foreach (order[r]) begin
            req = N'(1) << order[r];
            for (int t = 0; t < 6; t++) begin
                @(negedge clk);
                if (gnt != '0) break;
            end
            chk("frame_gnt", gnt, 1 << order[r]);
            req = '0;
        end
        repeat (2) @(negedge clk);
        chk("fd_once",    fd_seen - fd0, 1);
        chk("fd_with_g2", fd_g2 - fg0,   1);

        // Ungated build: vblank low does not block grants.
        vblank = 1'b0;
        req = 4'b0010;
        @(negedge clk);
        chk("nogate_wea", wea, 1);
        req = '0;
        @(negedge clk);

        // Requester 2 withdraws before ever being granted.
        req_addr[0 +: AW] = 3'd1; req_addr[2*AW +: AW] = 3'd5;
        g0cnt = 0; g2cnt = 0; bad5 = 0;
        req = 4'b0001;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (gnt[0]) g0cnt++;
            if (gnt[2]) g2cnt++;
            if (wea && addra == 3'd5) bad5++;
            if (j == 1) req = 4'b0101;
            else if (j == 2) req = 4'b0001;
            else if (j == 6) req = '0;
        end
        chk("withdrawn_g2", g2cnt, 0);
        chk("held_g0",      g0cnt, 3);
        chk("no_addr5",     bad5,  0);
        @(negedge clk);

        // Reset in the WRITE cycle drops the write; pointer restarts at 0.
        req = 4'b0010;
        @(negedge clk);
        chk("pre_rst_gnt", gnt, 4'b0010);
        reset = 1'b1; req = 4'b0110;
        @(negedge clk);
        chk("rst_wr_wea", wea, 0);
        chk("rst_wr_gnt", gnt, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("retry_gnt", gnt, 4'b0010);
        chk("retry_wea", wea, 1);
        req = '0;

        // Randomized traffic, vblank toggling and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            if ($urandom_range(0, 3) == 0) req_addr = (N*AW)'($urandom);
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
            if ($urandom_range(0, 19) == 0) vblank = ~vblank;
            reset = ($urandom_range(0, 299) == 0);
        end
        reset = 1'b0; req = '0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
